tx_arbiter_sequence_recorder: RTL

- Small dual-port FIFO that records the order in which the TX arbiter granted sources (A2P_1, A2P_2, Master, Rx Router CFG/ERR).
- Written by the TX arbiter FSM, one or two source IDs per cycle.
- Read by the TLP output/mux stage, one or two IDs per cycle, so packet data is replayed toward the DLL in grant order.
- Show-ahead: head entries are always visible on the read outputs.

---
 rtl/tx_arbiter_sequence_recorder_if.sv | 40 ++++
 rtl/tx_arbiter_sequence_recorder.sv | 98 +++++++++
 2 files changed

// File: rtl/tx_arbiter_sequence_recorder_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_arbiter_sequence_recorder_if
// Description : Write/read bus between the TX arbiter, the grant-order
//               recorder FIFO and the TLP output mux stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_arbiter_sequence_recorder_if #(
    parameter int DATA_WIDTH = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
);
    // Write side (TX arbiter FSM)
    logic                  wr_en;
    logic [1:0]            wr_mode;
    logic [DATA_WIDTH-1:0] wr_data_1;
    logic [DATA_WIDTH-1:0] wr_data_2;
    // Read side (TLP output mux)
    logic                  rd_en;
    logic [1:0]            rd_mode;
    logic [DATA_WIDTH-1:0] rd_data_1;
    logic [DATA_WIDTH-1:0] rd_data_2;
    // Status
    logic [ADDR_WIDTH:0]   available;
    logic                  wr_overflow;
    logic                  rd_underflow;

    // Arbiter/mux side drives requests and observes the FIFO
    modport master (
        output wr_en, wr_mode, wr_data_1, wr_data_2, rd_en, rd_mode,
        input  rd_data_1, rd_data_2, available, wr_overflow, rd_underflow
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_mode, wr_data_1, wr_data_2, rd_en, rd_mode,
        output rd_data_1, rd_data_2, available, wr_overflow, rd_underflow
    );
endinterface
`default_nettype wire

// File: rtl/tx_arbiter_sequence_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tx_arbiter_sequence_recorder
// Description : Show-ahead FIFO recording TX arbiter grant order. Accepts one
//               or two source IDs per cycle on write and pops one or two per
//               cycle on read; the two head entries are always visible.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter_sequence_recorder #(
    parameter int DATA_WIDTH = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  wire logic clk,
    input  wire logic arst_n,
    tx_arbiter_sequence_recorder_if.slave fifo_if
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_overflow;
    logic                  r_rd_underflow;

    logic [1:0]            w_n_wr;
    logic [1:0]            w_n_rd;
    logic [CNT_W-1:0]      w_available;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CNT_W-1:0]      w_wr_cnt;
    logic [CNT_W-1:0]      w_rd_cnt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_p1;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_p1;

    // Decode request sizes; modes 00/11 (or enable low) request nothing
    always_comb begin
        w_n_wr = 2'd0;
        w_n_rd = 2'd0;
        if (fifo_if.wr_en && fifo_if.wr_mode == 2'b01) w_n_wr = 2'd1;
        if (fifo_if.wr_en && fifo_if.wr_mode == 2'b10) w_n_wr = 2'd2;
        if (fifo_if.rd_en && fifo_if.rd_mode == 2'b01) w_n_rd = 2'd1;
        if (fifo_if.rd_en && fifo_if.rd_mode == 2'b10) w_n_rd = 2'd2;
    end

    // Acceptance uses start-of-cycle occupancy only: a same-cycle pop never
    // frees room for a write, and a same-cycle write is never read through.
    assign w_available = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_wr_acc    = (CNT_W'(w_n_wr) <= w_available);
    assign w_rd_acc    = (CNT_W'(w_n_rd) <= r_count);
    assign w_wr_cnt    = w_wr_acc ? CNT_W'(w_n_wr) : '0;
    assign w_rd_cnt    = w_rd_acc ? CNT_W'(w_n_rd) : '0;
    assign w_wr_ptr_p1 = r_wr_ptr + ADDR_WIDTH'(1);
    assign w_rd_ptr_p1 = r_rd_ptr + ADDR_WIDTH'(1);

    // Pointer, occupancy and rejection-pulse registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            r_wr_ptr       <= r_wr_ptr + ADDR_WIDTH'(w_wr_cnt);
            r_rd_ptr       <= r_rd_ptr + ADDR_WIDTH'(w_rd_cnt);
            r_count        <= r_count + w_wr_cnt - w_rd_cnt;
            r_wr_overflow  <= ~w_wr_acc;
            r_rd_underflow <= ~w_rd_acc;
        end
    end

    // Storage; a 2-entry write lands whole or not at all, wrapping the pointer
    always_ff @(posedge clk) begin
        if (w_wr_acc && w_n_wr != 2'd0) begin
            r_mem[r_wr_ptr] <= fifo_if.wr_data_1;
            if (w_n_wr == 2'd2) begin
                r_mem[w_wr_ptr_p1] <= fifo_if.wr_data_2;
            end
        end
    end

    // Show-ahead head entries, masked to NO_SOURCE when not valid
    always_comb begin
        fifo_if.rd_data_1 = '0;
        fifo_if.rd_data_2 = '0;
        if (r_count >= CNT_W'(1)) fifo_if.rd_data_1 = r_mem[r_rd_ptr];
        if (r_count >= CNT_W'(2)) fifo_if.rd_data_2 = r_mem[w_rd_ptr_p1];
    end

    assign fifo_if.available    = w_available;
    assign fifo_if.wr_overflow  = r_wr_overflow;
    assign fifo_if.rd_underflow = r_rd_underflow;

endmodule
`default_nettype wire
